// File: rtl/seq_encoder8to3.sv
// Sequential 8-to-3 encoder: emits the index of every set request bit, one per beat.
// Build option ENC_MSB_FIRST_EN: emit highest set bit first instead of lowest.
module seq_encoder8to3 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_code,
    output logic              out_last,
    output logic              none,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic             none_nxt;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_last;

    // Pick the next bit to emit; the last assignment in the loop wins.
    always_comb begin
        sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (pending[i]) sel_idx = IDXW'(i);
        end
`else
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = IDXW'(i);
        end
`endif
        sel_last = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            pending <= '0;
            none    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            none    <= none_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        none_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (data != '0) begin
                        pending_nxt = data;
                        state_nxt   = RUN;
                    end else begin
                        none_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(WIDTH'(1) << sel_idx);
                    if (sel_last) state_nxt = IDLE;
                end
            end
        endcase
    end

    // Outputs depend only on state and pending.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_code  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            default: begin
                out_valid = 1'b1;
                out_code  = sel_idx;
                out_last  = sel_last;
                busy      = 1'b1;
            end
        endcase
    end

endmodule
